seg7_capture: RTL and testbench

//   Receive side of the 4-digit multiplexed 7-segment interface (an/seg).

---
 rtl/seg7_capture.sv | 208 ++++++++++++++++++++
 tb/tb_seg7_capture.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// Receive side of a 4-digit multiplexed 7-segment bus: synchronises an/seg, waits for each
// dwell to settle, decodes the pattern back to a nibble and assembles four digits into a frame.
module seg7_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT_BITS  = 20
) (
  input  logic        clock,
  input  logic        Reset_n,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  blank,
  output logic        frame_valid,
  output logic        decode_err,
  output logic        stale
);

  localparam int unsigned STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [STAB_W-1:0]       STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STAB_W-1:0]       STAB_ONE  = 1;
  localparam logic [TIMEOUT_BITS-1:0] WDOG_ONE  = 1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HELD} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              an_meta_q, an_sync_q, an_prev_q;
  logic [6:0]              seg_meta_q, seg_sync_q, seg_prev_q;
  logic [STAB_W-1:0]       stab_q, stab_d;
  logic [3:0]              seen_q, seen_d;
  logic [TIMEOUT_BITS-1:0] wdog_q, wdog_d;
  logic [15:0]             digits_q, digits_d;
  logic [3:0]              dv_q, dv_d;
  logic [3:0]              blank_q, blank_d;
  logic                    fv_q, fv_d;
  logic                    err_q, err_d;
  logic                    stale_q, stale_d;

  logic       active_now, col_now, col_prev, same, capture;
  logic [1:0] k;
  logic [4:0] dec;
  logic [3:0] seen_next;

  function automatic logic [2:0] low_count(input logic [3:0] a);
    return 3'(!a[0]) + 3'(!a[1]) + 3'(!a[2]) + 3'(!a[3]);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] a);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!a[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // {legal, value}; active-low gfedcba
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    case (s)
      7'h40: return {1'b1, 4'h0};
      7'h79: return {1'b1, 4'h1};
      7'h24: return {1'b1, 4'h2};
      7'h30: return {1'b1, 4'h3};
      7'h19: return {1'b1, 4'h4};
      7'h12: return {1'b1, 4'h5};
      7'h02: return {1'b1, 4'h6};
      7'h78: return {1'b1, 4'h7};
      7'h00: return {1'b1, 4'h8};
      7'h10: return {1'b1, 4'h9};
      7'h08: return {1'b1, 4'hA};
      7'h03: return {1'b1, 4'hB};
      7'h46: return {1'b1, 4'hC};
      7'h21: return {1'b1, 4'hD};
      7'h06: return {1'b1, 4'hE};
      7'h0E: return {1'b1, 4'hF};
      default: return 5'b0;
    endcase
  endfunction

  assign active_now = (low_count(an_sync_q) == 3'd1);
  assign col_now    = (low_count(an_sync_q) > 3'd1);
  assign col_prev   = (low_count(an_prev_q) > 3'd1);
  assign same       = ({an_sync_q, seg_sync_q} == {an_prev_q, seg_prev_q});
  assign k          = low_index(an_sync_q);
  assign dec        = decode_seg(seg_sync_q);

  always_comb begin
    state_d   = state_q;
    stab_d    = stab_q;
    seen_d    = seen_q;
    digits_d  = digits_q;
    dv_d      = dv_q;
    blank_d   = blank_q;
    fv_d      = 1'b0;
    // one error pulse per collision episode, not one per cycle
    err_d     = col_now & ~col_prev;
    capture   = 1'b0;
    seen_next = seen_q;

    case (state_q)
      S_IDLE: begin
        if (active_now) begin
          state_d = S_SETTLE;
          stab_d  = '0;
        end
      end
      S_SETTLE: begin
        if (!active_now) begin
          state_d = S_IDLE;
        end else if (!same) begin
          stab_d = '0;
        end else if (stab_q == STAB_LAST) begin
          capture = 1'b1;
          state_d = S_HELD;
        end else begin
          stab_d = stab_q + STAB_ONE;
        end
      end
      S_HELD: begin
        if (!active_now) begin
          state_d = S_IDLE;
        end else if (!same) begin
          state_d = S_SETTLE;
          stab_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) wdog_d = '0;
    else if (wdog_q != '1) wdog_d = wdog_q + WDOG_ONE;
    else wdog_d = wdog_q;

    if (capture) begin
      if (dec[4]) begin
        digits_d[{k, 2'b00} +: 4] = dec[3:0];
        dv_d[k]    = 1'b1;
        blank_d[k] = 1'b0;
      end else if (seg_sync_q == 7'h7F) begin
        digits_d[{k, 2'b00} +: 4] = 4'h0;
        dv_d[k]    = 1'b1;
        blank_d[k] = 1'b1;
      end else begin
        dv_d[k]    = 1'b0;
        blank_d[k] = 1'b0;
        err_d      = 1'b1;
      end
      seen_next = seen_q | (4'b0001 << k);
      if (seen_next == 4'hF) begin
        fv_d   = 1'b1;
        seen_d = '0;
      end else begin
        seen_d = seen_next;
      end
    end else if (wdog_d == '1) begin
      dv_d   = '0;
      seen_d = '0;
    end

    stale_d = (wdog_d == '1);
  end

  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      an_meta_q  <= 4'hF;
      an_sync_q  <= 4'hF;
      an_prev_q  <= 4'hF;
      seg_meta_q <= 7'h7F;
      seg_sync_q <= 7'h7F;
      seg_prev_q <= 7'h7F;
      state_q    <= S_IDLE;
      stab_q     <= '0;
      seen_q     <= '0;
      wdog_q     <= '0;
      digits_q   <= '0;
      dv_q       <= '0;
      blank_q    <= '0;
      fv_q       <= 1'b0;
      err_q      <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      an_meta_q  <= an;
      an_sync_q  <= an_meta_q;
      an_prev_q  <= an_sync_q;
      seg_meta_q <= seg;
      seg_sync_q <= seg_meta_q;
      seg_prev_q <= seg_sync_q;
      state_q    <= state_d;
      stab_q     <= stab_d;
      seen_q     <= seen_d;
      wdog_q     <= wdog_d;
      digits_q   <= digits_d;
      dv_q       <= dv_d;
      blank_q    <= blank_d;
      fv_q       <= fv_d;
      err_q      <= err_d;
      stale_q    <= stale_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = dv_q;
  assign blank       = blank_q;
  assign frame_valid = fv_q;
  assign decode_err  = err_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: directed scenarios with literal expectations plus randomized dwells
// checked every cycle against a run-length based reference model.
module tb_seg7_capture;

  localparam int unsigned STABLE = 4;
  localparam int unsigned TBITS  = 5;
  localparam int          WMAX   = (1 << TBITS) - 1;

  logic        clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic [15:0] digits;
  logic [3:0]  digit_valid, blank;
  logic        frame_valid, decode_err, stale;

  seg7_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_BITS(TBITS)) dut (
    .clock(clock), .Reset_n(Reset_n), .an(an), .seg(seg),
    .digits(digits), .digit_valid(digit_valid), .blank(blank),
    .frame_valid(frame_valid), .decode_err(decode_err), .stale(stale)
  );

  always #5 clock = ~clock;

  logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] act_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [3:0] col_tab [6] = '{4'hC, 4'hA, 4'h9, 4'h6, 4'h5, 4'h0};

  int total = 0;
  int bad = 0;
  int fv_cnt = 0;
  int err_cnt = 0;
  bit chk_en = 1'b0;

  // reference model state
  logic [3:0] h1_an, h2_an, p_an;
  logic [6:0] h1_seg, h2_seg, p_seg;
  int         runlen, since;
  logic [3:0] m_dig [4];
  logic [3:0] m_dv, m_blank, m_seen;
  logic       m_fv, m_err, m_stale;

  function automatic int decode(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (codes[i] == s) return i;
    if (s == 7'h7F) return 16;
    return -1;
  endfunction

  task automatic model_reset();
    h1_an = 4'hF; h2_an = 4'hF; p_an = 4'hF;
    h1_seg = 7'h7F; h2_seg = 7'h7F; p_seg = 7'h7F;
    runlen = 1; since = 0;
    for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
    m_dv = '0; m_blank = '0; m_seen = '0;
    m_fv = 1'b0; m_err = 1'b0; m_stale = 1'b0;
  endtask

  // A capture happens on the sample that completes STABLE+1 identical active samples.
  task automatic model_step();
    logic [3:0] c_an;
    logic [6:0] c_seg;
    int lows, plows, k, d;
    bit cap;
    c_an = h2_an; c_seg = h2_seg;
    lows  = $countones(~c_an);
    plows = $countones(~p_an);
    if ({c_an, c_seg} == {p_an, p_seg}) begin
      if (runlen < 1000) runlen++;
    end else begin
      runlen = 1;
    end
    cap   = (lows == 1) && (runlen == STABLE + 1);
    m_fv  = 1'b0;
    m_err = (lows > 1) && !(plows > 1);
    if (cap) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (!c_an[i]) k = i;
      d = decode(c_seg);
      if (d >= 0 && d < 16) begin
        m_dig[k] = d[3:0]; m_dv[k] = 1'b1; m_blank[k] = 1'b0;
      end else if (d == 16) begin
        m_dig[k] = 4'h0; m_dv[k] = 1'b1; m_blank[k] = 1'b1;
      end else begin
        m_dv[k] = 1'b0; m_blank[k] = 1'b0; m_err = 1'b1;
      end
      m_seen[k] = 1'b1;
      if (m_seen == 4'hF) begin
        m_fv = 1'b1; m_seen = '0;
      end
      since = 0;
    end else begin
      if (since < WMAX) since++;
      if (since == WMAX) begin
        m_dv = '0; m_seen = '0;
      end
    end
    m_stale = (since == WMAX);
    p_an = c_an; p_seg = c_seg;
    h2_an = h1_an; h2_seg = h1_seg;
    h1_an = an; h1_seg = seg;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge Reset_n);
      if (!Reset_n) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) begin
        chk("digits", digits, {m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
        chk("digit_valid", digit_valid, m_dv);
        chk("blank", blank, m_blank);
        chk("frame_valid", frame_valid, m_fv);
        chk("decode_err", decode_err, m_err);
        chk("stale", stale, m_stale);
        if (frame_valid) fv_cnt++;
        if (decode_err) err_cnt++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
    an = a; seg = s;
    tick(n);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_digits"}, digits, 0);
    chk({tag, "_dv"}, digit_valid, 0);
    chk({tag, "_blank"}, blank, 0);
    chk({tag, "_fv"}, frame_valid, 0);
    chk({tag, "_err"}, decode_err, 0);
    chk({tag, "_stale"}, stale, 0);
  endtask

  initial begin
    int f0, e0, r, len;
    tick(3);
    chk_en = 1'b1;
    chk_all_zero("reset");
    Reset_n = 1'b1;
    tick(2);

    // too-short dwell never captures
    dwell(4'hE, 7'h79, 3);
    dwell(4'hF, 7'h7F, 12);
    chk("short_dv0", digit_valid, 0);
    chk("short_digits", digits, 0);

    // pins-to-output latency 2 + STABLE + 1
    an = 4'hE; seg = 7'h30;
    tick(6);
    chk("lat_before", digit_valid, 0);
    tick(1);
    chk("lat_at", digit_valid, 4'b0001);
    chk("lat_digits", digits, 16'h0003);
    tick(9);

    f0 = fv_cnt;
    for (int rr = 0; rr < 2; rr++) begin
      dwell(4'hE, 7'h0E, 16);
      dwell(4'hD, 7'h30, 16);
      dwell(4'hB, 7'h08, 16);
      dwell(4'h7, 7'h79, 16);
    end
    chk("scan_digits", digits, 16'h1A3F);
    chk("scan_dv", digit_valid, 4'hF);
    chk("scan_frames", fv_cnt - f0, 2);

    dwell(4'hB, 7'h7F, 16);
    chk("blank_bits", blank, 4'b0100);
    chk("blank_dv", digit_valid, 4'hF);
    chk("blank_digits", digits, 16'h103F);

    e0 = err_cnt;
    dwell(4'hD, 7'h55, 16);
    chk("illegal_err", err_cnt - e0, 1);
    chk("illegal_dv", digit_valid, 4'b1101);
    chk("illegal_digits", digits, 16'h103F);

    e0 = err_cnt;
    dwell(4'hC, 7'h40, 16);
    chk("collide_err", err_cnt - e0, 1);
    chk("collide_digits", digits, 16'h103F);
    chk("collide_dv", digit_valid, 4'b1101);

    dwell(4'hF, 7'h7F, 40);
    chk("stale_set", stale, 1);
    chk("stale_dv", digit_valid, 0);
    an = 4'hE; seg = 7'h40;
    tick(6);
    chk("stale_hold", stale, 1);
    tick(1);
    chk("stale_clear", stale, 0);
    chk("recover_dv", digit_valid, 4'b0001);
    chk("recover_digits", digits, 16'h1030);
    tick(9);

    // reset in the middle of the fourth dwell discards the partial frame
    dwell(4'hE, 7'h0E, 16);
    dwell(4'hD, 7'h30, 16);
    dwell(4'hB, 7'h08, 16);
    dwell(4'h7, 7'h79, 3);
    Reset_n = 1'b0;
    tick(2);
    chk_all_zero("midrst");
    an = 4'hF; seg = 7'h7F;
    Reset_n = 1'b1;
    tick(2);
    f0 = fv_cnt;
    dwell(4'hE, 7'h0E, 16);
    dwell(4'hD, 7'h30, 16);
    dwell(4'hB, 7'h08, 16);
    chk("post_rst_noframe", fv_cnt - f0, 0);
    dwell(4'h7, 7'h79, 16);
    chk("post_rst_frame", fv_cnt - f0, 1);
    chk("post_rst_digits", digits, 16'h1A3F);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 65) an = act_tab[$urandom_range(0, 3)];
      else if (r < 80) an = 4'hF;
      else an = col_tab[$urandom_range(0, 5)];
      r = $urandom_range(0, 99);
      if (r < 70) seg = codes[$urandom_range(0, 15)];
      else if (r < 85) seg = 7'h7F;
      else seg = 7'($urandom);
      len = ($urandom_range(0, 99) < 5) ? 45 : $urandom_range(1, 20);
      tick(len);
      if ($urandom_range(0, 99) == 0) begin
        Reset_n = 1'b0;
        tick(2);
        Reset_n = 1'b1;
      end
    end
    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
